// File: rtl/exp5_unidade_controle_if.sv
// Control/status bundle between the memory-game control unit and its datapath.
// master = control unit side, slave = datapath side.
interface exp5_unidade_controle_if #(
    parameter int ESTADO_W = 4
);
    // status flags from the datapath
    logic                iniciar;
    logic                jogada_feita;
    logic                igual;
    logic                enderecoIgualLimite;
    logic                fimE;
    logic                controle_timeout;
    // controls towards the datapath
    logic                zeraE;
    logic                contaE;
    logic                zeraL;
    logic                contaL;
    logic                zeraR;
    logic                registraR;
    logic                contaT;
    logic                pronto;
    logic                acertou;
    logic                errou;
    logic                timeout;
    logic [ESTADO_W-1:0] db_estado;

    modport master (
        input  iniciar, jogada_feita, igual, enderecoIgualLimite, fimE, controle_timeout,
        output zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT,
               pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, jogada_feita, igual, enderecoIgualLimite, fimE, controle_timeout,
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT,
               pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/exp5_unidade_controle.sv
// Moore control FSM for the memory game: rounds of growing length, play compare, win/lose/timeout.
// Latency: outputs decoded from the state register, valid right after each rising clock edge.
// Backpressure: none; the FSM parks in ESPERA_JOGADA until a play pulse. Macro TIMEOUT_EN enables the play timeout.
module exp5_unidade_controle #(
    parameter int ESTADO_W        = 4,
    parameter bit REINICIA_DIRETO = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    exp5_unidade_controle_if.master     bus
);

    localparam logic [ESTADO_W-1:0] INICIAL        = ESTADO_W'(4'h0);
    localparam logic [ESTADO_W-1:0] PREPARACAO     = ESTADO_W'(4'h1);
    localparam logic [ESTADO_W-1:0] INICIO_RODADA  = ESTADO_W'(4'h2);
    localparam logic [ESTADO_W-1:0] ESPERA_JOGADA  = ESTADO_W'(4'h3);
    localparam logic [ESTADO_W-1:0] REGISTRA       = ESTADO_W'(4'h4);
    localparam logic [ESTADO_W-1:0] COMPARACAO     = ESTADO_W'(4'h5);
    localparam logic [ESTADO_W-1:0] PROXIMA_JOGADA = ESTADO_W'(4'h6);
    localparam logic [ESTADO_W-1:0] PROXIMA_RODADA = ESTADO_W'(4'h8);
    localparam logic [ESTADO_W-1:0] FIM_ACERTOU    = ESTADO_W'(4'hA);
    localparam logic [ESTADO_W-1:0] FIM_TIMEOUT    = ESTADO_W'(4'hE);
    localparam logic [ESTADO_W-1:0] FIM_ERROU      = ESTADO_W'(4'hF);

    logic [ESTADO_W-1:0] estado;
    logic [ESTADO_W-1:0] estado_nxt;
    logic                reinicia;

    assign reinicia = bus.iniciar && REINICIA_DIRETO;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_nxt;
        end
    end

    always_comb begin
        estado_nxt = INICIAL;
        case (estado)
            INICIAL:        estado_nxt = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_nxt = INICIO_RODADA;
            INICIO_RODADA:  estado_nxt = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // a play arriving together with the timeout still counts
                if (bus.jogada_feita) begin
                    estado_nxt = REGISTRA;
`ifdef TIMEOUT_EN
                end else if (bus.controle_timeout) begin
                    estado_nxt = FIM_TIMEOUT;
`endif
                end else begin
                    estado_nxt = ESPERA_JOGADA;
                end
            end
            REGISTRA:       estado_nxt = COMPARACAO;
            COMPARACAO: begin
                if (!bus.igual) begin
                    estado_nxt = FIM_ERROU;
                end else if (bus.enderecoIgualLimite && bus.fimE) begin
                    estado_nxt = FIM_ACERTOU;
                end else if (bus.enderecoIgualLimite) begin
                    estado_nxt = PROXIMA_RODADA;
                end else begin
                    estado_nxt = PROXIMA_JOGADA;
                end
            end
            PROXIMA_JOGADA: estado_nxt = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_nxt = INICIO_RODADA;
            FIM_ACERTOU:    estado_nxt = reinicia ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:      estado_nxt = reinicia ? PREPARACAO : FIM_ERROU;
`ifdef TIMEOUT_EN
            FIM_TIMEOUT:    estado_nxt = reinicia ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:        estado_nxt = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraE     = 1'b0;
        bus.contaE    = 1'b0;
        bus.zeraL     = 1'b0;
        bus.contaL    = 1'b0;
        bus.zeraR     = 1'b0;
        bus.registraR = 1'b0;
        bus.contaT    = 1'b0;
        bus.pronto    = 1'b0;
        bus.acertou   = 1'b0;
        bus.errou     = 1'b0;
        bus.timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                bus.zeraR = 1'b1;
            end
            INICIO_RODADA: begin
                bus.zeraE = 1'b1;
                bus.zeraR = 1'b1;
            end
`ifdef TIMEOUT_EN
            ESPERA_JOGADA:  bus.contaT    = 1'b1;
`endif
            REGISTRA:       bus.registraR = 1'b1;
            PROXIMA_JOGADA: bus.contaE    = 1'b1;
            PROXIMA_RODADA: bus.contaL    = 1'b1;
            FIM_ACERTOU: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
            end
            FIM_ERROU: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                bus.pronto  = 1'b1;
                bus.timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.db_estado = estado;

`ifndef TIMEOUT_EN
    logic unused_controle_timeout;
    assign unused_controle_timeout = bus.controle_timeout;
`endif

endmodule
